// File: rtl/fir_pkg.sv
// Shared types, constants and the accumulator saturation helper
// for the time-multiplexed FIR core.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        DONE
    } fir_state_t;

    localparam int N_DEF  = 16;
    localparam int Q_FRAC = N_DEF / 2;

    localparam logic [N_DEF-1:0] SAT_POS = 16'h7FFF;
    localparam logic [N_DEF-1:0] SAT_NEG = 16'h8000;

    // Clamp a sign-extended accumulator into the signed range of an n-bit word.
    function automatic logic signed [31:0] sat_acc(
        input logic signed [31:0] acc,
        input int                 n
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (n - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (n - 1));
        if (acc > hi) begin
            sat_acc = hi;
        end else if (acc < lo) begin
            sat_acc = lo;
        end else begin
            sat_acc = acc;
        end
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS x N register file with one write port and one combinational
// read port; serves as both the sample history and the coefficient bank.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter  int N    = 16,
    parameter  int TAPS = 8,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem_q [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR core: one sample in, TAPS multiply-accumulate
// steps through the external multiplier, one saturated sample out.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter  int N    = 16,
    parameter  int TAPS = 8,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_wdata,
    output logic [N-1:0]  mul_a,
    output logic [N-1:0]  mul_b,
    input  logic [N-1:0]  mul_p,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready
);

    fir_state_t state_q, state_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] rd_k;
    logic [AW-1:0] x_raddr;

    logic signed [N+AW-1:0] acc_q, acc_d;

    logic [N-1:0] mul_a_q, mul_a_d;
    logic [N-1:0] mul_b_q, mul_b_d;
    logic [N-1:0] out_q, out_d;
    logic [N-1:0] x_rdata, h_rdata;

    logic x_we, h_we;

    assign x_we = (state_q == IDLE) && in_valid;
    assign h_we = (state_q == IDLE) && coef_we;

    // While accumulating tap k, the operands for tap k+1 are fetched.
    assign rd_k    = (state_q == MAC) ? k_q + AW'(1) : k_q;
    assign x_raddr = wr_ptr_q - rd_k;

    fir_delay_line #(
        .N    (N),
        .TAPS (TAPS)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (x_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (x_raddr),
        .rdata (x_rdata)
    );

    fir_delay_line #(
        .N    (N),
        .TAPS (TAPS)
    ) u_coef (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (h_we),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .raddr (rd_k),
        .rdata (h_rdata)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        acc_d    = acc_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        out_d    = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mul_a_d = x_rdata;
                mul_b_d = h_rdata;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + {{AW{mul_p[N-1]}}, mul_p};
                k_d   = k_q + AW'(1);
                if (k_q == AW'(TAPS - 1)) begin
                    out_d    = N'(sat_acc(32'(acc_d), N));
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    state_d  = DONE;
                end else begin
                    mul_a_d = x_rdata;
                    mul_b_d = h_rdata;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            out_q    <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer (TAPS=4) with a saturating Q8.8 multiplier
// and a convolution reference model over sample/coefficient arrays.
module tb_fir_mac_sequencer;

    localparam int N    = 16;
    localparam int TAPS = 4;
    localparam int AW   = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_wdata;
    logic [N-1:0]  mul_a;
    logic [N-1:0]  mul_b;
    logic [N-1:0]  mul_p;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] hist [TAPS];
    logic [N-1:0] h    [TAPS];
    logic [N-1:0] last_y;

    logic [N-1:0] tbl_a [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0400};
    logic [N-1:0] tbl_b [5] = '{16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0000};
    logic [N-1:0] h_b   [4] = '{16'h0080, 16'h0040, 16'h0020, 16'h0010};

    always #5 clk = ~clk;

    // Saturating Q8.8 multiplier: full product, arithmetic shift, clamp.
    function automatic logic [N-1:0] mul_q(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa;
        int sb;
        int p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = (sa * sb) >>> 8;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return N'(p);
    endfunction

    assign mul_p = mul_q(mul_a, mul_b);

    fir_mac_sequencer #(
        .N    (N),
        .TAPS (TAPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) begin
            hist[i] = '0;
            h[i]    = '0;
        end
    endfunction

    function automatic void model_push(input logic [N-1:0] x);
        for (int i = TAPS - 1; i > 0; i--) begin
            hist[i] = hist[i-1];
        end
        hist[0] = x;
    endfunction

    // y[n] = sat( sum_k h[k] * x[n-k] )
    function automatic logic [N-1:0] model_y();
        int s;
        s = 0;
        for (int k = 0; k < TAPS; k++) begin
            s += int'($signed(mul_q(hist[k], h[k])));
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return N'(s);
    endfunction

    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
        check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic wr_coef(input logic [AW-1:0] k, input logic [N-1:0] v);
        coef_we    = 1'b1;
        coef_addr  = k;
        coef_wdata = v;
        h[k]       = v;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Push one sample; optional same-cycle coef write (cw) or an
    // ignored coef write while the MAC loop is running (midw).
    task automatic send(input logic [N-1:0] x, input bit cw, input logic [AW-1:0] ca,
                        input logic [N-1:0] cv, input bit midw);
        logic [N-1:0] exp;
        int cnt;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        if (cw) begin
            coef_we    = 1'b1;
            coef_addr  = ca;
            coef_wdata = cv;
            h[ca]      = cv;
        end
        model_push(x);
        exp = model_y();
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        in_data  = N'($urandom);
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            coef_we = midw && (cnt == 3);
            if (coef_we) begin
                coef_addr  = AW'($urandom);
                coef_wdata = N'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        coef_we = 1'b0;
        check("latency", 32'(cnt), 32'(TAPS + 2));
        last_y = out_data;
        if (out_valid) begin
            check("y", 32'(out_data), 32'(exp));
        end
        @(negedge clk);
        check("out_valid_clr", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [N-1:0] exp_bp;
        logic [N-1:0] v;
        int cnt;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        out_ready  = 1'b1;
        last_y     = '0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset("rst0");

        for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'h0100);
        for (int i = 0; i < 5; i++) begin
            send(16'h0100, 1'b0, '0, '0, 1'b0);
            check("ramp_tbl", 32'(last_y), 32'(tbl_a[i]));
        end

        do_reset("rstB");
        for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), h_b[k]);
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 16'h0100 : 16'h0000, 1'b0, '0, '0, 1'b0);
            check("impulse_tbl", 32'(last_y), 32'(tbl_b[i]));
        end

        do_reset("rstC");
        for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'h7F00);
        for (int i = 0; i < 4; i++) begin
            send(16'h7F00, 1'b0, '0, '0, 1'b0);
            check("sat_pos", 32'(last_y), 32'h7FFF);
        end
        do_reset("rstC2");
        for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'h7F00);
        for (int i = 0; i < 4; i++) begin
            send(16'h8100, 1'b0, '0, '0, 1'b0);
            check("sat_neg", 32'(last_y), 32'h8000);
        end

        // Output back-pressure: held output, input blocked.
        check("bp_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h0180;
        model_push(16'h0180);
        exp_bp = model_y();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_latency", 32'(cnt), 32'(TAPS + 2));
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(exp_bp));
            check("bp_in_ready_lo", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            in_data  = N'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_data_rel", 32'(out_data), 32'(exp_bp));
        @(negedge clk);
        check("bp_done_valid", 32'(out_valid), 32'd0);
        send(16'h0040, 1'b0, '0, '0, 1'b0);

        // Coefficient writes outside IDLE are dropped; same-cycle write is used.
        send(16'h0200, 1'b0, '0, '0, 1'b1);
        send(16'hFF00, 1'b0, '0, '0, 1'b1);
        send(16'h0100, 1'b1, 2'd0, 16'h0040, 1'b0);
        send(16'h0300, 1'b1, 2'd3, 16'hFF80, 1'b0);

        // Reset while the MAC loop runs with history present.
        check("rf_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h0500;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        do_reset("rstF");
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_in_ready2", 32'(in_ready), 32'd1);
        for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), h_b[k]);
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 16'h0100 : 16'h0000, 1'b0, '0, '0, 1'b0);
            check("rf_impulse", 32'(last_y), 32'(tbl_b[i]));
        end

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            v = N'($urandom);
            if ($urandom_range(0, 1) == 1) v = {{5{v[10]}}, v[10:0]};
            if ($urandom_range(0, 3) == 0) begin
                wr_coef(AW'($urandom), N'($urandom));
            end else begin
                send(v, ($urandom_range(0, 3) == 0), AW'($urandom), N'($urandom),
                     ($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
